// File: rtl/simple_processor_pkg.sv
// Shared constants and types for the simple processor control unit.
// The optional IllegalOp flag is enabled with SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN.
package simple_processor_pkg;

    localparam int INSTR_W_C  = 9;
    localparam int NUM_REGS_C = 8;

    localparam int OPC_MSB = 8;
    localparam int X_LSB   = 3;
    localparam int Y_LSB   = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MVI = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_e;

    function automatic logic is_illegal(input logic [2:0] opc);
        return opc[2];
    endfunction

endpackage

// File: rtl/simple_processor_if.sv
// Control-side bundle between DIN/Run and the datapath enables.
// IllegalOp exists only when SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN is defined.
interface simple_processor_if;
    import simple_processor_pkg::*;

    logic                  Run;
    logic [INSTR_W_C-1:0]  DIN;
    logic [INSTR_W_C-1:0]  IRout;
    logic [NUM_REGS_C-1:0] Rin;
    logic [NUM_REGS_C-1:0] Rout;
    logic                  Gout;
    logic                  DINout;
    logic                  Ain;
    logic                  Gin;
    logic                  AddSub;
    logic                  Done;
`ifdef SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN
    logic                  IllegalOp;
`endif

    modport master (
        output Run, DIN,
        input  IRout, Rin, Rout, Gout, DINout,
        input  Ain, Gin, AddSub, Done
`ifdef SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN
        , input IllegalOp
`endif
    );

    modport slave (
        input  Run, DIN,
        output IRout, Rin, Rout, Gout, DINout,
        output Ain, Gin, AddSub, Done
`ifdef SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN
        , output IllegalOp
`endif
    );

endinterface

// File: rtl/simple_processor_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero when disabled.
module simple_processor_dec3to8 (
    input  logic [2:0] w_i,
    input  logic       en_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = 8'h00;
        if (en_i) y_o[w_i] = 1'b1;
    end

endmodule

// File: rtl/simple_processor_control.sv
// Sequencer for the 9-bit simple processor: fetch in T0, execute in T1..T3.
// Define SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN to add the sticky IllegalOp flag.
module simple_processor_control
    import simple_processor_pkg::*;
#(
    parameter int INSTR_W  = 9,
    parameter int NUM_REGS = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    simple_processor_if.slave   ctl
);

    localparam logic [1:0] S_T0 = T0;
    localparam logic [1:0] S_T1 = T1;
    localparam logic [1:0] S_T2 = T2;
    localparam logic [1:0] S_T3 = T3;

    if (INSTR_W != INSTR_W_C || NUM_REGS != NUM_REGS_C) begin : g_bad_cfg
        $error("simple_processor_control: INSTR_W must be 9, NUM_REGS 8");
    end

    logic [1:0]           state_q, state_d;
    logic [INSTR_W_C-1:0] ir_q, ir_d;

    logic [2:0] opc, fx, fy;
    logic [2:0] rin_sel, rout_sel;
    logic       rin_en, rout_en;
    logic       gout, dinout, ain, gin, addsub, done;

    assign opc = ir_q[OPC_MSB -: 3];
    assign fx  = ir_q[X_LSB +: 3];
    assign fy  = ir_q[Y_LSB +: 3];

    always_comb begin
        state_d  = S_T0;
        ir_d     = ir_q;
        rin_en   = 1'b0;
        rin_sel  = fx;
        rout_en  = 1'b0;
        rout_sel = fy;
        gout     = 1'b0;
        dinout   = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_T0: begin
                if (ctl.Run) begin
                    ir_d    = ctl.DIN;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                case (opc)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin_en = 1'b1;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_sel = fx;
                        rout_en  = 1'b1;
                        ain      = 1'b1;
                        state_d  = S_T2;
                    end
                    // illegal opcodes complete as a NOP
                    default: done = 1'b1;
                endcase
            end
            S_T2: begin
                rout_en = 1'b1;
                gin     = 1'b1;
                addsub  = (opc == OP_SUB);
                state_d = S_T3;
            end
            S_T3: begin
                gout   = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: state_d = S_T0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    simple_processor_dec3to8 u_dec_rin (
        .w_i  (rin_sel),
        .en_i (rin_en),
        .y_o  (ctl.Rin)
    );

    simple_processor_dec3to8 u_dec_rout (
        .w_i  (rout_sel),
        .en_i (rout_en),
        .y_o  (ctl.Rout)
    );

    assign ctl.IRout  = ir_q;
    assign ctl.Gout   = gout;
    assign ctl.DINout = dinout;
    assign ctl.Ain    = ain;
    assign ctl.Gin    = gin;
    assign ctl.AddSub = addsub;
    assign ctl.Done   = done;

`ifdef SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN
    logic ill_q, ill_d;

    assign ill_d = ill_q | ((state_q == S_T1) & is_illegal(opc));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) ill_q <= 1'b0;
        else       ill_q <= ill_d;
    end

    assign ctl.IllegalOp = ill_q;
`endif

endmodule

// File: tb/tb_simple_processor_control.sv
// Directed testbench for simple_processor_control.
// Define SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN to also check IllegalOp.
module tb_simple_processor_control;

    logic Clock;
    logic Reset;
    int   n_cmp;
    int   n_bad;

    simple_processor_if bus ();

    simple_processor_control dut (
        .Clock (Clock),
        .Reset (Reset),
        .ctl   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done}
    logic [21:0] obs;
    assign obs = {bus.Rin, bus.Rout, bus.Gout, bus.DINout,
                  bus.Ain, bus.Gin, bus.AddSub, bus.Done};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        bus.Run = 1'b0;
        bus.DIN = 9'h1FF;
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_outs got %h want %h", obs, 22'h0);
        end
        n_cmp++;
        if (bus.IRout !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_ir got %h want %h", bus.IRout, 9'h000);
        end
        Reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.IRout !== 9'h000 || obs !== 22'h0) begin
            n_bad++;
            $display("FAIL idle_hold got ir=%h outs=%h want ir=000 outs=0",
                     bus.IRout, obs);
        end
    endtask

    task automatic test_mvi();
        bus.Run = 1'b1;
        bus.DIN = 9'b011_010_001;
        tick();
        bus.Run = 1'b0;
        bus.DIN = 9'h1FF;
        n_cmp++;
        if (obs !== {8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL mvi_t1 got %h want %h", obs,
                     {8'h04, 8'h00, 6'b010001});
        end
        n_cmp++;
        if (bus.IRout !== 9'b011_010_001) begin
            n_bad++;
            $display("FAIL mvi_ir got %h want %h", bus.IRout, 9'b011_010_001);
        end
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL mvi_t0 got %h want 0", obs);
        end
    endtask

    task automatic test_mv();
        bus.Run = 1'b1;
        bus.DIN = 9'b000_001_010;
        tick();
        bus.Run = 1'b0;
        n_cmp++;
        if (obs !== {8'h02, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL mv_t1 got %h want %h", obs,
                     {8'h02, 8'h04, 6'b000001});
        end
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL mv_t0 got %h want 0", obs);
        end
    endtask

    task automatic test_sub();
        bus.Run = 1'b1;
        bus.DIN = 9'b010_011_101;
        tick();
        bus.Run = 1'b0;
        n_cmp++;
        if (obs !== {8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_t1 got %h want %h", obs,
                     {8'h00, 8'h08, 6'b001000});
        end
        tick();
        n_cmp++;
        if (obs !== {8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_t2 got %h want %h", obs,
                     {8'h00, 8'h20, 6'b000110});
        end
        tick();
        n_cmp++;
        if (obs !== {8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_t3 got %h want %h", obs,
                     {8'h08, 8'h00, 6'b100001});
        end
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL sub_t0 got %h want 0", obs);
        end
    endtask

    task automatic test_add_same_reg();
        bus.Run = 1'b1;
        bus.DIN = 9'b001_010_010;
        tick();
        n_cmp++;
        if (obs !== {8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_t1 got %h want %h", obs,
                     {8'h00, 8'h04, 6'b001000});
        end
        tick();
        n_cmp++;
        if (obs !== {8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_t2 got %h want %h", obs,
                     {8'h00, 8'h04, 6'b000100});
        end
        tick();
        n_cmp++;
        if (obs !== {8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL add_t3 got %h want %h", obs,
                     {8'h04, 8'h00, 6'b100001});
        end
        bus.Run = 1'b0;
        tick();
    endtask

    task automatic test_run_drop();
        bus.Run = 1'b1;
        bus.DIN = 9'b001_111_000;
        tick();
        bus.Run = 1'b0;
        bus.DIN = 9'h000;
        tick();
        tick();
        n_cmp++;
        if (obs !== {8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL run_drop_t3 got %h want %h", obs,
                     {8'h80, 8'h00, 6'b100001});
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== 22'h0 || bus.IRout !== 9'b001_111_000) begin
            n_bad++;
            $display("FAIL run_drop_idle got ir=%h outs=%h want ir=%h outs=0",
                     bus.IRout, obs, 9'b001_111_000);
        end
    endtask

    task automatic test_reset_mid();
        bus.Run = 1'b1;
        bus.DIN = 9'b001_010_011;
        tick();
        bus.Run = 1'b0;
        tick();
        n_cmp++;
        if (bus.Gin !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre got gin=%b want 1", bus.Gin);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 22'h0 || bus.IRout !== 9'h000) begin
            n_bad++;
            $display("FAIL rst_mid_async got ir=%h outs=%h want 0/0",
                     bus.IRout, obs);
        end
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL rst_mid_held got %h want 0", obs);
        end
        Reset = 1'b0;
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL rst_mid_after got %h want 0", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        int         nsrc;
        bus.Run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.DIN = {3'b011, 3'(i), 3'b000};
            tick();
            want = 8'h01 << i;
            nsrc = int'(bus.Rout != 8'h00) + int'(bus.Gout) + int'(bus.DINout);
            n_cmp++;
            if (bus.Done !== 1'b1 || bus.Rin !== want || nsrc > 1) begin
            n_bad++;
                $display("FAIL b2b_t1[%0d] got done=%b rin=%h srcs=%0d want 1 %h <=1",
                         i, bus.Done, bus.Rin, nsrc, want);
            end
            tick();
            n_cmp++;
            if (bus.Done !== 1'b0 || bus.Rin !== 8'h00) begin
                n_bad++;
                $display("FAIL b2b_t0[%0d] got done=%b rin=%h want 0 00",
                         i, bus.Done, bus.Rin);
            end
        end
        bus.Run = 1'b0;
    endtask

    task automatic test_illegal();
        bus.Run = 1'b1;
        bus.DIN = 9'b111_000_000;
        tick();
        bus.Run = 1'b0;
        n_cmp++;
        if (obs !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ill_t1 got %h want %h", obs, 22'h1);
        end
        tick();
        n_cmp++;
        if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL ill_t0 got %h want 0", obs);
        end
`ifdef SIMPLE_PROC_CTRL_ILLEGAL_FLAG_EN
        n_cmp++;
        if (bus.IllegalOp !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_flag got %b want 1", bus.IllegalOp);
        end
        bus.Run = 1'b1;
        bus.DIN = 9'b000_001_010;
        tick();
        bus.Run = 1'b0;
        tick();
        n_cmp++;
        if (bus.IllegalOp !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_sticky got %b want 1", bus.IllegalOp);
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.IllegalOp !== 1'b0) begin
            n_bad++;
            $display("FAIL ill_clear got %b want 0", bus.IllegalOp);
        end
        Reset = 1'b0;
        tick();
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mvi();
        test_mv();
        test_sub();
        test_add_same_reg();
        test_run_drop();
        test_reset_mid();
        test_back_to_back();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
